// File: rtl/branch_predictor_sat.sv
// ============================================================================
// Module   : branch_predictor_sat
// Brief    : Direct-mapped branch target/direction predictor with saturating
//            counters, post-reset table-clear sweep and write-first lookup.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predictor_sat #(
    parameter int ENTRIES = 512,
    parameter int CNT_W   = 2,
    parameter int ADDR_W  = $clog2(ENTRIES),
    parameter int TAG_W   = 30 - ADDR_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_pc,
    input  logic        next_pc_valid,
    input  logic [31:0] if_pc,
    input  logic [31:0] dec_pc,
    input  logic        branch_ex,
    input  logic [31:0] ex_pc,
    input  logic        branch_taken,
    input  logic [31:0] jump_pc,
    input  logic [31:0] njump_pc,
    output logic [31:0] predicted_pc,
    output logic        prediction,
    output logic        use_prediction,
    output logic        flush,
    output logic        init_busy
);

    typedef enum logic [0:0] {INIT = 1'b0, ACTIVE = 1'b1} state_t;

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_weak_nt = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] c_weak_t  = CNT_W'(1 << (CNT_W - 1));

    logic              mem_valid [ENTRIES];
    logic [TAG_W-1:0]  mem_tag   [ENTRIES];
    logic [CNT_W-1:0]  mem_cnt   [ENTRIES];
    logic [31:0]       mem_tgt   [ENTRIES];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] sweep_q, sweep_d;
    logic              lk_valid_q, lk_valid_d;
    logic [TAG_W-1:0]  lk_tag_q, lk_tag_d;
    logic [CNT_W-1:0]  lk_cnt_q, lk_cnt_d;
    logic [31:0]       lk_tgt_q, lk_tgt_d;
    logic              req_q, req_d;

    logic              w_we;
    logic [ADDR_W-1:0] w_wr_idx;
    logic              w_wr_valid;
    logic [TAG_W-1:0]  w_wr_tag;
    logic [CNT_W-1:0]  w_wr_cnt;
    logic [31:0]       w_wr_tgt;

    logic [ADDR_W-1:0] w_ex_idx, w_lk_idx;
    logic [TAG_W-1:0]  w_ex_tag, w_if_tag;
    logic [CNT_W-1:0]  w_ex_cnt;
    logic              w_ex_hit, w_hit;
    logic              unused_pc_bits;

    assign w_ex_idx = ex_pc[ADDR_W+1:2];
    assign w_ex_tag = ex_pc[31:32-TAG_W];
    assign w_lk_idx = next_pc[ADDR_W+1:2];
    assign w_if_tag = if_pc[31:32-TAG_W];
    assign w_ex_cnt = mem_cnt[w_ex_idx];
    assign w_ex_hit = mem_valid[w_ex_idx] && (mem_tag[w_ex_idx] == w_ex_tag);
    assign unused_pc_bits = ^{next_pc[31:ADDR_W+2], next_pc[1:0], ex_pc[1:0]};

    // Single write port shared by the clear sweep and execute-stage training
    always_comb begin
        w_we       = 1'b0;
        w_wr_idx   = sweep_q;
        w_wr_valid = 1'b0;
        w_wr_tag   = '0;
        w_wr_cnt   = c_weak_nt;
        w_wr_tgt   = 32'h0;
        if (state_q == INIT) begin
            w_we = 1'b1;
        end else if (branch_ex) begin
            w_we       = 1'b1;
            w_wr_idx   = w_ex_idx;
            w_wr_valid = 1'b1;
            w_wr_tag   = w_ex_tag;
            if (w_ex_hit) begin
                w_wr_tgt = branch_taken ? jump_pc : mem_tgt[w_ex_idx];
                if (branch_taken)
                    w_wr_cnt = (w_ex_cnt == c_cnt_max) ? w_ex_cnt : w_ex_cnt + CNT_W'(1);
                else
                    w_wr_cnt = (w_ex_cnt == '0) ? w_ex_cnt : w_ex_cnt - CNT_W'(1);
            end else begin
                w_wr_cnt = branch_taken ? c_weak_t : c_weak_nt;
                w_wr_tgt = branch_taken ? jump_pc : 32'h0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            mem_valid[w_wr_idx] <= w_wr_valid;
            mem_tag[w_wr_idx]   <= w_wr_tag;
            mem_cnt[w_wr_idx]   <= w_wr_cnt;
            mem_tgt[w_wr_idx]   <= w_wr_tgt;
        end
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        if (state_q == INIT) begin
            sweep_d = sweep_q + ADDR_W'(1);
            if (sweep_q == ADDR_W'(ENTRIES - 1))
                state_d = ACTIVE;
        end
        // Write-first: a same-edge write to the looked-up index wins
        if (w_we && (w_wr_idx == w_lk_idx)) begin
            lk_valid_d = w_wr_valid;
            lk_tag_d   = w_wr_tag;
            lk_cnt_d   = w_wr_cnt;
            lk_tgt_d   = w_wr_tgt;
        end else begin
            lk_valid_d = mem_valid[w_lk_idx];
            lk_tag_d   = mem_tag[w_lk_idx];
            lk_cnt_d   = mem_cnt[w_lk_idx];
            lk_tgt_d   = mem_tgt[w_lk_idx];
        end
        req_d = next_pc_valid;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= INIT;
            sweep_q    <= '0;
            lk_valid_q <= 1'b0;
            lk_tag_q   <= '0;
            lk_cnt_q   <= '0;
            lk_tgt_q   <= 32'h0;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sweep_q    <= sweep_d;
            lk_valid_q <= lk_valid_d;
            lk_tag_q   <= lk_tag_d;
            lk_cnt_q   <= lk_cnt_d;
            lk_tgt_q   <= lk_tgt_d;
            req_q      <= req_d;
        end
    end

    assign w_hit          = lk_valid_q && (lk_tag_q == w_if_tag) && req_q && (state_q == ACTIVE);
    assign use_prediction = w_hit;
    assign prediction     = w_hit && lk_cnt_q[CNT_W-1];
    // Held at zero while clearing so reset drives every prediction output low
    assign predicted_pc   = (state_q != ACTIVE) ? 32'h0 :
                            prediction ? lk_tgt_q : if_pc + 32'd4;
    assign init_busy      = (state_q == INIT);
    assign flush          = branch_ex && (branch_taken ? (dec_pc != jump_pc) : (dec_pc != njump_pc));

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor_sat.sv
// ============================================================================
// Module   : tb_branch_predictor_sat
// Brief    : Directed self-checking bench for branch_predictor_sat (8 entries).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_predictor_sat;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] next_pc = 32'h0;
    logic        next_pc_valid = 1'b0;
    logic [31:0] if_pc = 32'h0;
    logic [31:0] dec_pc = 32'h0;
    logic        branch_ex = 1'b0;
    logic [31:0] ex_pc = 32'h0;
    logic        branch_taken = 1'b0;
    logic [31:0] jump_pc = 32'h0;
    logic [31:0] njump_pc = 32'h0;
    logic [31:0] predicted_pc;
    logic        prediction;
    logic        use_prediction;
    logic        flush;
    logic        init_busy;

    int errors = 0;
    int checks = 0;

    branch_predictor_sat #(.ENTRIES(8), .CNT_W(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .next_pc        (next_pc),
        .next_pc_valid  (next_pc_valid),
        .if_pc          (if_pc),
        .dec_pc         (dec_pc),
        .branch_ex      (branch_ex),
        .ex_pc          (ex_pc),
        .branch_taken   (branch_taken),
        .jump_pc        (jump_pc),
        .njump_pc       (njump_pc),
        .predicted_pc   (predicted_pc),
        .prediction     (prediction),
        .use_prediction (use_prediction),
        .flush          (flush),
        .init_busy      (init_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic train(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        branch_ex     = 1'b1;
        ex_pc         = pc;
        branch_taken  = taken;
        jump_pc       = tgt;
        njump_pc      = pc + 32'd4;
        dec_pc        = taken ? tgt : pc + 32'd4;
        next_pc_valid = 1'b0;
        tick();
        branch_ex     = 1'b0;
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc,
                          input logic exp_use, input logic exp_pred, input logic [31:0] exp_pc);
        next_pc       = pc;
        if_pc         = pc;
        next_pc_valid = 1'b1;
        tick();
        check({tag, "_use"},  {31'h0, use_prediction}, {31'h0, exp_use});
        check({tag, "_pred"}, {31'h0, prediction},     {31'h0, exp_pred});
        check({tag, "_pc"},   predicted_pc,            exp_pc);
        next_pc_valid = 1'b0;
    endtask

    // Releases reset and measures the sweep length; a lookup stays pending throughout
    task automatic sweep(input string tag);
        int n;
        logic seen_use;
        n        = 0;
        seen_use = 1'b0;
        rst      = 1'b1;
        while (init_busy && n < 40) begin
            tick();
            n++;
            if (init_busy && use_prediction) seen_use = 1'b1;
        end
        check({tag, "_len"}, n, 32'd8);
        check({tag, "_use_in_init"}, {31'h0, seen_use}, 32'h0);
    endtask

    initial begin
        if_pc = 32'h1234;
        tick();
        tick();
        check("rst_busy", {31'h0, init_busy},      32'h1);
        check("rst_use",  {31'h0, use_prediction}, 32'h0);
        check("rst_pred", {31'h0, prediction},     32'h0);
        check("rst_pc",   predicted_pc,            32'h0);

        next_pc       = 32'h100;
        if_pc         = 32'h100;
        next_pc_valid = 1'b1;
        sweep("sweep1");
        check("first_active_use", {31'h0, use_prediction}, 32'h0);
        next_pc_valid = 1'b0;

        // Allocate taken, then counter walks 2->3->3->2->1->0->0->1->2
        train(32'h100, 1'b1, 32'h200);
        check("train_noflush", {31'h0, flush}, 32'h0);
        lookup("alloc", 32'h100, 1'b1, 1'b1, 32'h200);
        train(32'h100, 1'b1, 32'h200);
        train(32'h100, 1'b1, 32'h200);
        train(32'h100, 1'b0, 32'h0);
        lookup("sat_c2", 32'h100, 1'b1, 1'b1, 32'h200);
        train(32'h100, 1'b0, 32'h0);
        lookup("sat_c1", 32'h100, 1'b1, 1'b0, 32'h104);
        train(32'h100, 1'b0, 32'h0);
        train(32'h100, 1'b0, 32'h0);
        train(32'h100, 1'b1, 32'h200);
        lookup("floor_c1", 32'h100, 1'b1, 1'b0, 32'h104);
        train(32'h100, 1'b1, 32'h200);
        lookup("floor_c2", 32'h100, 1'b1, 1'b1, 32'h200);

        // Aliasing PC 0x120 shares index 0 with 0x100
        lookup("alias_miss", 32'h120, 1'b0, 1'b0, 32'h124);
        train(32'h120, 1'b1, 32'h300);
        lookup("alias_hit", 32'h120, 1'b1, 1'b1, 32'h300);
        lookup("alias_old", 32'h100, 1'b0, 1'b0, 32'h104);
        train(32'h120, 1'b0, 32'h0);
        lookup("alias_c1", 32'h120, 1'b1, 1'b0, 32'h124);

        // Not-taken allocation lands at weak not-taken
        train(32'h104, 1'b0, 32'h0);
        lookup("nt_alloc", 32'h104, 1'b1, 1'b0, 32'h108);
        train(32'h104, 1'b1, 32'h500);
        lookup("nt_up", 32'h104, 1'b1, 1'b1, 32'h500);

        // Flush decode and write-first forwarding
        branch_ex    = 1'b1;
        ex_pc        = 32'h10;
        branch_taken = 1'b1;
        jump_pc      = 32'h40;
        njump_pc     = 32'h14;
        dec_pc       = 32'h44;
        #1 check("flush_t_bad", {31'h0, flush}, 32'h1);
        dec_pc = 32'h40;
        #1 check("flush_t_ok", {31'h0, flush}, 32'h0);
        branch_taken = 1'b0;
        dec_pc       = 32'h14;
        #1 check("flush_nt_ok", {31'h0, flush}, 32'h0);
        dec_pc = 32'h40;
        #1 check("flush_nt_bad", {31'h0, flush}, 32'h1);
        branch_taken  = 1'b1;
        next_pc       = 32'h10;
        if_pc         = 32'h10;
        next_pc_valid = 1'b1;
        tick();
        branch_ex     = 1'b0;
        next_pc_valid = 1'b0;
        check("fwd_use",  {31'h0, use_prediction}, 32'h1);
        check("fwd_pred", {31'h0, prediction},     32'h1);
        check("fwd_pc",   predicted_pc,            32'h40);
        dec_pc = 32'h99;
        #1 check("flush_idle", {31'h0, flush}, 32'h0);

        // Asynchronous reset mid-operation
        rst = 1'b0;
        #1;
        check("mrst_use",  {31'h0, use_prediction}, 32'h0);
        check("mrst_pred", {31'h0, prediction},     32'h0);
        check("mrst_pc",   predicted_pc,            32'h0);
        check("mrst_busy", {31'h0, init_busy},      32'h1);
        tick();
        tick();
        next_pc_valid = 1'b1;
        sweep("sweep2");
        lookup("post_rst", 32'h10, 1'b0, 1'b0, 32'h14);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/branch_predictor_sat.md
Name: branch_predictor_sat

Overview:
- Parametrised direct-mapped branch target/direction predictor for the fetch stage.
- Next generation of the single-bit branch table: adds CNT_W-bit saturating direction counters, parametrised depth/tag width, hardware table-clear sequencer after reset, and write-first lookup forwarding.
- Looks up next_pc one cycle ahead of fetch and is trained by the execute stage; raises flush on misprediction.

Parameters:
- ENTRIES, 512, table depth; power of two, >=4.
- CNT_W, 2, direction counter width; 1..4.
- ADDR_W, $clog2(ENTRIES), index width; index = pc[ADDR_W+1:2].
- TAG_W, 30-ADDR_W, tag width; tag = pc[31:32-TAG_W].

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- next_pc  in  32  fetch lookup address.
- next_pc_valid  in  1  lookup request qualifier.
- if_pc  in  32  PC in fetch, one cycle after its next_pc presentation.
- dec_pc  in  32  PC fetched after the branch now in execute.
- branch_ex  in  1  resolved branch in execute this cycle.
- ex_pc  in  32  PC of resolved branch.
- branch_taken  in  1  resolved direction.
- jump_pc  in  32  resolved taken target.
- njump_pc  in  32  fall-through address.
- predicted_pc  out  32  predicted next PC for if_pc.
- prediction  out  1  predicted direction, 1 = taken.
- use_prediction  out  1  predicted_pc/prediction are valid for if_pc.
- flush  out  1  misprediction, combinational.
- init_busy  out  1  table-clear sweep in progress.

Behaviour:
- Entry = {valid, tag[TAG_W], cnt[CNT_W], target[32]}. RAM has no reset; clearing is done by the sequencer.
- FSM states: INIT, ACTIVE. rst low: state=INIT, sweep index=0, predicted_pc=0, prediction=0, use_prediction=0, init_busy=1, all asynchronous.
- INIT: one entry per cycle, index 0..ENTRIES-1, written {valid=0, tag=0, cnt=2^(CNT_W-1)-1, target=0}. ENTRIES cycles total, then ACTIVE. init_busy=1 throughout, 0 from the first ACTIVE cycle. Training writes ignored; use_prediction=0.
- rst asserted mid-sweep or in ACTIVE: immediate return to INIT; sweep restarts at 0.
- Lookup, 1-cycle latency: edge N registers entry[next_pc index] and next_pc_valid. In cycle N+1:
  - hit = valid & (tag == if_pc tag) & registered next_pc_valid & ACTIVE.
  - use_prediction = hit.
  - prediction = cnt MSB, forced 0 when hit=0.
  - predicted_pc = target when prediction=1; otherwise if_pc+4, mod 2^32.
- Training, ACTIVE & branch_ex: asynchronous read of entry[ex_pc index]; write-back on the same edge.
  - Tag hit on valid entry: cnt saturating +1 if taken, -1 if not taken; holds at 2^CNT_W-1 and 0. target=jump_pc if taken, else unchanged.
  - Miss: allocate {valid=1, tag=ex_pc tag, cnt=taken ? 2^(CNT_W-1) : 2^(CNT_W-1)-1, target=taken ? jump_pc : 0}.
- Same-index lookup and training on one edge: write-first. The registered lookup returns the newly written entry.
- flush = branch_ex & (branch_taken ? dec_pc!=jump_pc : dec_pc!=njump_pc). Independent of FSM state and table contents.
- CNT_W=1 degenerates to last-outcome prediction. Weak states: not-taken = 2^(CNT_W-1)-1, taken = 2^(CNT_W-1).

Test Plan:
- Reset sweep: ENTRIES=8, release rst -> init_busy=1 for exactly 8 cycles, then 0. Lookup of any PC -> use_prediction=0.
- Allocate/hit: ACTIVE, train ex_pc=0x100, taken, jump_pc=0x200. Then next_pc=if_pc=0x100, next_pc_valid=1 -> next cycle use_prediction=1, prediction=1, predicted_pc=0x200.
- Saturation, CNT_W=2: 0x100 trained taken 3 times, then not-taken once -> cnt=2, prediction=1. Not-taken again -> cnt=1, prediction=0, predicted_pc=0x104.
- Alias/tag miss: after training 0x100, lookup 0x100+4*ENTRIES -> use_prediction=0. Training that PC taken to 0x300 replaces the entry: cnt=2, target=0x300.
- Flush and forwarding: branch_ex=1, taken, jump_pc=0x40, dec_pc=0x44 -> flush=1 the same cycle; dec_pc=0x40 -> flush=0. Same-cycle lookup of ex_pc -> next-cycle hit with target 0x40.
- Mid-operation reset: assert rst during ACTIVE with use_prediction=1 -> outputs 0 immediately; after release, a full ENTRIES-cycle sweep; previously trained PC misses.
